// File: rtl/wide_add_sequencer_pkg.sv
// Shared definitions for the chunked wide adder: FSM encoding and slice width.
package wide_add_sequencer_pkg;

  localparam int CHUNK_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/wide_add_sequencer_fulladd16.sv
// 16-bit combinational full adder slice, time-shared by wide_add_sequencer.
module fulladd16 (
  output logic [15:0] sum,
  output logic        c_out,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in
);

  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {16'd0, c_in};

endmodule

// File: rtl/wide_add_sequencer.sv
// WIDTH-bit add/subtract computed one 16-bit chunk per clock through a single fulladd16,
// with valid/ready handshakes on both the request and the result side.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for a request; in_ready=1
// ST_RUN  | one chunk per clock, LSB chunk first, carry held in carry_q
// ST_DONE | result/c_out valid and held until out_ready
module wide_add_sequencer
  import wide_add_sequencer_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK_W;
  localparam int IDX_W  = $clog2(NCHUNK) + 1;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;
  logic [WIDTH-1:0]   a_q, b_q, result_q;
  logic               c_out_q;

  logic [CHUNK_W-1:0] slice_a, slice_b, slice_sum;
  logic               slice_c_out;
  logic               last_chunk;

  assign slice_a    = a_q[int'(idx_q)*CHUNK_W +: CHUNK_W];
  assign slice_b    = b_q[int'(idx_q)*CHUNK_W +: CHUNK_W];
  assign last_chunk = (idx_q == IDX_W'(NCHUNK - 1));

  fulladd16 u_slice (
    .sum   (slice_sum),
    .c_out (slice_c_out),
    .a     (slice_a),
    .b     (slice_b),
    .c_in  (carry_q)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (last_chunk) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy    = 1'b0;
      end
    endcase
  end

  // Subtraction is folded into the accept: B is stored inverted and the carry seeded with 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      c_out_q  <= 1'b0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q     <= op_a;
            b_q     <= sub ? ~op_b : op_b;
            carry_q <= sub ? 1'b1 : c_in;
            idx_q   <= '0;
          end
        end
        ST_RUN: begin
          result_q[int'(idx_q)*CHUNK_W +: CHUNK_W] <= slice_sum;
          carry_q <= slice_c_out;
          idx_q   <= idx_q + 1'b1;
          if (last_chunk) c_out_q <= slice_c_out;
        end
        default: ;
      endcase
    end
  end

  assign result = result_q;
  assign c_out  = c_out_q;

endmodule
